// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: state encoding,
// matrix geometry and the latched-hit record.
package keypad_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KEY_W   = 4;

  typedef enum logic [1:0] {SCAN, CHECK, DEBOUNCE, HELD} kp_state_e;

  typedef struct packed {
    logic [1:0]         row;
    logic [1:0]         col;
    logic [KP_COLS-1:0] pat;
  } kp_hit_t;

  // Lowest-indexed active (low) column; caller guarantees at least one is low.
  function automatic logic [1:0] low_col(input logic [KP_COLS-1:0] cols);
    low_col = 2'd0;
    for (int i = KP_COLS - 1; i >= 0; i--)
      if (!cols[i]) low_col = 2'(i);
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the press-event outputs; master = scanner side.
interface keypad_scanner_if;
  import keypad_pkg::*;
  logic [KP_COLS-1:0]         col_n;
  logic [KP_ROWS-1:0]         row_n;
  logic [KP_ROWS*KP_COLS-1:0] key_pulse;
  logic [KEY_W-1:0]           key_code;
  logic                       key_held;

  modport master(input col_n, output row_n, key_pulse, key_code, key_held);
  modport slave (output col_n, input row_n, key_pulse, key_code, key_held);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Parameterised-width two-flop synchroniser; resets to all ones (idle
// level of a pulled-up, active-low input).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and a one-cycle
// one-hot press strobe. Define KEYPAD_REPEAT_EN to add auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 64,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic              clk,
  input logic              rst_n,
  keypad_scanner_if.master kp
);
  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  logic [KP_COLS-1:0]         cols;
  kp_state_e                  state_q, state_d;
  logic [1:0]                 row_q, row_d;
  logic [KP_ROWS-1:0]         row_n_q, row_n_d;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_inc;
  kp_hit_t                    hit_q, hit_d;
  logic [KP_ROWS*KP_COLS-1:0] key_pulse_q, key_pulse_d;
  logic [KEY_W-1:0]           key_code_q, key_code_d;
  logic                       key_held_q, key_held_d;

  sync_2ff #(.W(KP_COLS)) u_sync (.clk(clk), .rst_n(rst_n), .d(kp.col_n), .q(cols));

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_q, rpt_d, rpt_last;
  logic          first_q, first_d;

  assign rpt_last = first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    key_pulse_d = '0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    first_d     = first_q;
`endif
    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (cols != '1) begin
          hit_d.row = row_q;
          hit_d.col = low_col(cols);
          hit_d.pat = cols;
          state_d   = DEBOUNCE;
        end else begin
          row_d   = row_q + 2'd1;
          state_d = SCAN;
        end
      end
      DEBOUNCE: begin
        // Any change in the pattern, including an extra key, starts over.
        if (cols != hit_q.pat) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d                               = '0;
          key_pulse_d[{hit_q.row, hit_q.col}] = 1'b1;
          key_code_d                          = {hit_q.row, hit_q.col};
          key_held_d                          = 1'b1;
          state_d                             = HELD;
`ifdef KEYPAD_REPEAT_EN
          rpt_d   = '0;
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (cols != '1) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          row_d      = row_q + 2'd1;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat timer free-runs in HELD; a tick only strobes while something is down.
        if (rpt_q == rpt_last) begin
          rpt_d   = '0;
          first_d = 1'b0;
          if (cols != '1) key_pulse_d[{hit_q.row, hit_q.col}] = 1'b1;
        end else begin
          rpt_d = rpt_q + RW'(1);
        end
`endif
      end
      default: state_d = SCAN;
    endcase
    row_n_d = ~(KP_ROWS'(1) << row_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      cnt_q       <= '0;
      hit_q       <= '0;
      key_pulse_q <= '0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
      first_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      key_pulse_q <= key_pulse_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
      first_q     <= first_d;
`endif
    end
  end

  assign kp.row_n     = row_n_q;
  assign kp.key_pulse = key_pulse_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives col_n from row_n, and a
// sequential reference thread predicts every output cycle by cycle.
module tb_keypad_scanner;
  localparam int SETTLE = 4;
  localparam int DEB    = 16;
  localparam int RDLY   = 40;
  localparam int RPER   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (.clk(clk), .rst_n(rst_n), .kp(kif));

  // Physical matrix: a pressed key shorts its row to its column.
  logic [15:0] keys = '0;
  always_comb begin
    kif.col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  exp_row_n;
  logic [15:0] exp_pulse;
  logic [3:0]  exp_code;
  logic        exp_held;
  logic [3:0]  hist [0:2];
  bit          abort;
  int          mdl_phase;

  task automatic tick();
    @(posedge clk or negedge rst_n);
    if (!rst_n) abort = 1;
    else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = kif.col_n;
      exp_pulse = '0;
    end
  endtask

  task automatic run();
    int r, c, n, q, rk, tgt;
    logic [3:0] pat;
    r = 0;
    forever begin
      mdl_phase = 0;
      repeat (SETTLE) begin tick(); if (abort) return; end
      tick(); if (abort) return;
      if (hist[2] == 4'hF) begin
        r = (r + 1) % 4;
        exp_row_n = ~(4'b0001 << r);
        continue;
      end
      pat = hist[2];
      c = 0;
      while (pat[c]) c++;
      mdl_phase = 1;
      n = 0;
      while (n < DEB) begin
        tick(); if (abort) return;
        if (hist[2] != pat) break;
        n++;
      end
      if (n < DEB) continue;
      exp_pulse = 16'(1) << (r*4 + c);
      exp_code  = 4'(r*4 + c);
      exp_held  = 1'b1;
      mdl_phase = 2;
      q = 0; rk = 0; tgt = RDLY;
      while (q < DEB) begin
        tick(); if (abort) return;
        q = (hist[2] == 4'hF) ? q + 1 : 0;
`ifdef KEYPAD_REPEAT_EN
        rk++;
        if (rk == tgt) begin
          rk = 0; tgt = RPER;
          if (hist[2] != 4'hF) exp_pulse = 16'(1) << (r*4 + c);
        end
`endif
      end
      exp_held = 1'b0;
      r = (r + 1) % 4;
      exp_row_n = ~(4'b0001 << r);
    end
  endtask

  initial begin
    forever begin
      abort = 0;
      exp_row_n = 4'b1110; exp_pulse = '0; exp_code = '0; exp_held = 1'b0;
      hist[0] = 4'hF; hist[1] = 4'hF; hist[2] = 4'hF;
      mdl_phase = 0;
      wait (rst_n === 1'b1);
      run();
    end
  end

  // ---------------- compare + pulse monitor ----------------
  int          pulse_cnt = 0;
  logic [15:0] last_pulse = '0;
  always @(negedge clk) begin
    chk("row_n", 32'(kif.row_n), 32'(exp_row_n));
    chk("key_pulse", 32'(kif.key_pulse), 32'(exp_pulse));
    chk("key_code", 32'(kif.key_code), 32'(exp_code));
    chk("key_held", 32'(kif.key_held), 32'(exp_held));
  end
  always @(negedge clk) if (kif.key_pulse != '0) begin
    pulse_cnt++;
    last_pulse = kif.key_pulse;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int ph, input string nm);
    for (int i = 0; i < 200 && mdl_phase != ph; i++) cyc(1);
    chk(nm, 32'(mdl_phase), 32'(ph));
  endtask

  initial begin
    int base, n, hold, g, k;
    cyc(3);
    chk("rst_row_n", 32'(kif.row_n), 32'h000E);
    chk("rst_pulse", 32'(kif.key_pulse), 32'h0);
    chk("rst_code", 32'(kif.key_code), 32'h0);
    chk("rst_held", 32'(kif.key_held), 32'h0);
    rst_n = 1'b1;

    // Idle scan: row changes after every CHECK edge, i.e. every 5 cycles.
    repeat (4) @(posedge clk);
    @(negedge clk) chk("scan_r0", 32'(kif.row_n), 32'hE);
    @(negedge clk) chk("scan_r1", 32'(kif.row_n), 32'hD);
    repeat (5) @(negedge clk);
    chk("scan_r2", 32'(kif.row_n), 32'hB);
    repeat (5) @(negedge clk);
    chk("scan_r3", 32'(kif.row_n), 32'h7);
    repeat (5) @(negedge clk);
    chk("scan_wrap", 32'(kif.row_n), 32'hE);
    chk("idle_npulse", 32'(pulse_cnt), 32'h0);
    #2;

    // Row 2 col 1 held 100 cycles.
    base = pulse_cnt;
    keys[9] = 1'b1;
    cyc(100);
    chk("k9_held", 32'(kif.key_held), 32'h1);
    keys = '0;
    cyc(60);
    chk("k9_npulse", 32'(pulse_cnt - base), 32'h1);
    chk("k9_pulse", 32'(last_pulse), 32'h0200);
    chk("k9_code", 32'(kif.key_code), 32'h9);
    chk("k9_release", 32'(kif.key_held), 32'h0);

    // Bouncing contact, then stable.
    base = pulse_cnt;
    for (int i = 0; i < 12; i++) begin keys[6] = ~keys[6]; cyc(5); end
    chk("bounce_npulse", 32'(pulse_cnt - base), 32'h0);
    keys[6] = 1'b1;
    cyc(60);
    chk("bounce_stable_n", 32'(pulse_cnt - base), 32'h1);
    chk("bounce_pulse", 32'(last_pulse), 32'h0040);
    keys = '0; cyc(40);

    // Two keys in one row: lowest column wins.
    base = pulse_cnt;
    keys[1] = 1'b1; keys[3] = 1'b1;
    cyc(60);
    chk("multi_n", 32'(pulse_cnt - base), 32'h1);
    chk("multi_pulse", 32'(last_pulse), 32'h0002);
    keys = '0; cyc(40);

    // Adding col 0 mid-debounce restarts and re-evaluates the pattern.
    base = pulse_cnt;
    keys[1] = 1'b1; keys[3] = 1'b1;
    wait_phase(1, "add_reach_deb");
    cyc(5);
    keys[0] = 1'b1;
    cyc(60);
    chk("add_n", 32'(pulse_cnt - base), 32'h1);
    chk("add_pulse", 32'(last_pulse), 32'h0001);
    keys = '0; cyc(40);

    // Reset 8 cycles into debounce; re-debounce from scratch afterwards.
    base = pulse_cnt;
    keys[2] = 1'b1;
    wait_phase(1, "rst_reach_deb");
    cyc(8);
    rst_n = 1'b0;
    #1;
    chk("midrst_row_n", 32'(kif.row_n), 32'hE);
    chk("midrst_pulse", 32'(kif.key_pulse), 32'h0);
    chk("midrst_held", 32'(kif.key_held), 32'h0);
    chk("midrst_npulse", 32'(pulse_cnt - base), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    for (n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (kif.key_pulse != '0) break;
    end
    chk("rearm_latency", 32'(n), 32'(SETTLE + 1 + DEB));
    chk("rearm_pulse", 32'(kif.key_pulse), 32'h0004);
    #2;
    keys = '0; cyc(40);

`ifdef KEYPAD_REPEAT_EN
    base = pulse_cnt;
    keys[5] = 1'b1;
    wait_phase(2, "rpt_accept");
    cyc(121);
    chk("rpt_n", 32'(pulse_cnt - base), 32'h6);
    keys = '0; cyc(40);
`endif

    // Randomized presses, chords, glitches and occasional resets.
    for (int it = 0; it < 30; it++) begin
      k = int'($urandom_range(0, 15));
      keys = 16'(1) << k;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      hold = int'($urandom_range(5, 90));
      if ($urandom_range(0, 3) == 0) begin
        cyc(hold / 2);
        g = int'($urandom_range(0, 15));
        keys[g] = ~keys[g];
        cyc(int'($urandom_range(1, 3)));
        keys[g] = ~keys[g];
        cyc(hold / 2);
      end else begin
        cyc(hold);
      end
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      keys = '0;
      cyc(int'($urandom_range(5, 40)));
    end
    cyc(60);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low key matrix, debounces the detected key and emits exactly one single-cycle, one-hot press pulse per key press. It sits directly upstream of the hex-entry display controller: `key_pulse[i]` drives button input `b_<i>` (bit 0 to `b_0`, bit 15 to `b_f`). Column inputs are asynchronous to `clk` and are synchronised internally.

## Interface
- `SETTLE_CYCLES`, default 64: cycles a row is driven before its columns are sampled; legal values are 1 or greater.
- `DEBOUNCE_CYCLES`, default 500000: cycles of stable input required to accept a press or a release; legal values are 1 or greater.
- `REPEAT_DELAY`, default 25000000: cycles from press acceptance to the first repeat; used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeats; used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `col_n`  in  4  matrix column sense, active low, externally pulled up, asynchronous.
- `row_n`  out  4  matrix row drive, active low, exactly one bit low at all times.
- `key_pulse`  out  16  one-hot press strobe, one cycle wide; bit index = row*4 + col.
- `key_code`  out  4  index of the last accepted key, held until the next acceptance.
- `key_held`  out  1  high while the accepted key is held down.

## Operation
- Columns pass through a 2-flop synchroniser; "cols" below means the synchronised value. A column is active when its bit is 0.
- The state machine has four states: SCAN, CHECK, DEBOUNCE and HELD.
- SCAN: drive row `r` and wait `SETTLE_CYCLES`, then go to CHECK.
- CHECK, in one cycle:
  - If any column is low, latch `r`, latch the lowest-indexed active column `c`, latch the full cols pattern, and go to DEBOUNCE.
  - Otherwise set `r` to `(r+1) mod 4` and go to SCAN.
- DEBOUNCE: the row stays driven. Each cycle where cols equals the latched pattern increments the counter.
  - Any mismatch clears the counter and returns the machine to SCAN on the same row.
  - When the counter reaches `DEBOUNCE_CYCLES`: assert `key_pulse[r*4+c]` for one cycle, load `key_code`, set `key_held`, and go to HELD.
- HELD: the row stays driven. The machine waits for cols == 4'hF for `DEBOUNCE_CYCLES` consecutive cycles; any low column restarts that count.
  - On completion: clear `key_held`, advance `r`, and go to SCAN.
  - Keys pressed in other rows during HELD are ignored.
- Multiple keys in one row: the lowest column wins. A change in the pattern during DEBOUNCE (a second key added or removed) restarts debounce.
- Counters are sized to the width of `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `SETTLE_CYCLES` and saturate; they never wrap.

## Timing
- Reset values:
  - `row_n` = 4'b1110 (row 0)
  - `key_pulse` = 0
  - `key_code` = 0
  - `key_held` = 0
  - state = SCAN; all counters and synchroniser flops = 0 / 4'hF.
- Reset asserted mid-press: everything returns to the reset values immediately. No pulse is produced for the interrupted press, and after reset deassertion the key must be debounced again from scratch.
- Latency from a clean column edge to `key_pulse` is at most 2 (sync) + 1 (CHECK) + `DEBOUNCE_CYCLES` + 1 cycles once the row is being driven. Worst case adds up to 4×(`SETTLE_CYCLES`+1) cycles of scan time.
- `key_pulse` has at most one bit set and is high for exactly one cycle. It is registered.
- `row_n` changes only on the SCAN entry of a new row.

## Configuration
- With `KEYPAD_REPEAT_EN` defined, HELD runs a repeat counter:
  - The first extra pulse for the same key occurs `REPEAT_DELAY` cycles after acceptance.
  - Further pulses follow every `REPEAT_PERIOD` cycles while the key stays held.
  - Release debounce still applies.
- Without `KEYPAD_REPEAT_EN`: no repeat counter is built, the two repeat parameters are ignored, and only one pulse is produced per press.

## Structure
- Package `keypad_pkg` holds:
  - the state encoding (SCAN, CHECK, DEBOUNCE, HELD)
  - `KP_ROWS`=4 and `KP_COLS`=4
  - the key-index width of 4.
- One sub-module, `sync_2ff`, a parameterised-width 2-flop synchroniser with reset value of all ones. It is instantiated for `col_n`.

## Test plan
All scenarios use `SETTLE_CYCLES`=4 and `DEBOUNCE_CYCLES`=16; the repeat scenario also uses `REPEAT_DELAY`=40 and `REPEAT_PERIOD`=20.
- Reset release, no keys -> `row_n` cycles 1110→1101→1011→0111→1110 every 5 cycles; `key_pulse` stays 0.
- Key row 2 col 1 held for 100 cycles -> exactly one pulse on `key_pulse` = 16'h0200, `key_code` = 9, `key_held` high until 16 cycles after release.
- Column bouncing with period 5 cycles for 60 cycles, then stable -> no pulse during the bounce and exactly one pulse after 16 stable cycles.
- Row 0 cols 1 and 3 pressed together -> pulse on bit 1 only. Adding col 0 during DEBOUNCE restarts the count, then the pulse is on bit 0.
- Reset asserted 8 cycles into DEBOUNCE -> outputs return to the reset values, and no pulse is produced until a full re-debounce.
- With `KEYPAD_REPEAT_EN` defined, key 5 held for 120 cycles after acceptance -> pulses at +0, +40, +60, +80, +100 and +120.
